// File: rtl/centroid_pkg.sv
// Shared types, widths and helpers for the centroid divide sequencer.
package centroid_pkg;

    localparam int DIV_BITS = 30;
    localparam int SUM1_W   = 20;
    localparam int SUMXY_W  = 29;
    localparam int COORD_W  = 10;
    localparam int CNT_W    = 5;

    typedef enum logic [1:0] {
        IDLE,
        DIV_X,
        DIV_Y,
        PUBLISH
    } state_t;

    // Clamp a full-width quotient to lim, then keep the coordinate bits.
    function automatic logic [COORD_W-1:0] saturate(
        input logic [DIV_BITS-1:0] q,
        input logic [DIV_BITS-1:0] lim
    );
        return COORD_W'((q > lim) ? lim : q);
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Serial radix-2 restoring divider: one quotient bit per cycle, DIV_BITS bits.
// The first quotient bit is produced on the load edge, so q_valid follows DIV_BITS edges later.
module seq_divider
    import centroid_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [DIV_BITS-1:0] dividend,
    input  logic [SUM1_W-1:0]   divisor,
    output logic [DIV_BITS-1:0] quotient,
    output logic                q_valid
);

    logic [SUM1_W-1:0]   rem_reg, rem_next;
    logic [DIV_BITS-1:0] sh_reg, sh_next;
    logic [SUM1_W-1:0]   div_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                run_reg;
    logic                q_valid_reg;

    logic [SUM1_W-1:0]   src_rem;
    logic [DIV_BITS-1:0] src_sh;
    logic [SUM1_W-1:0]   src_div;
    logic [SUM1_W:0]     trial;
    logic                ge;

    always_comb begin
        src_rem = load ? '0 : rem_reg;
        src_sh  = load ? dividend : sh_reg;
        src_div = load ? divisor : div_reg;
        trial   = {src_rem, src_sh[DIV_BITS-1]};
        ge      = (trial >= {1'b0, src_div});
        // Remainder stays below the divisor, so 20-bit wraparound subtraction is exact.
        rem_next = ge ? (trial[SUM1_W-1:0] - src_div) : trial[SUM1_W-1:0];
        sh_next  = {src_sh[DIV_BITS-2:0], ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_reg     <= '0;
            sh_reg      <= '0;
            div_reg     <= '0;
            cnt_reg     <= '0;
            run_reg     <= 1'b0;
            q_valid_reg <= 1'b0;
        end else if (load) begin
            rem_reg     <= rem_next;
            sh_reg      <= sh_next;
            div_reg     <= divisor;
            cnt_reg     <= CNT_W'(1);
            run_reg     <= 1'b1;
            q_valid_reg <= 1'b0;
        end else if (run_reg) begin
            rem_reg     <= rem_next;
            sh_reg      <= sh_next;
            cnt_reg     <= cnt_reg + CNT_W'(1);
            q_valid_reg <= (cnt_reg == CNT_W'(DIV_BITS - 1));
            if (cnt_reg == CNT_W'(DIV_BITS - 1)) begin
                run_reg <= 1'b0;
            end
        end else begin
            q_valid_reg <= 1'b0;
        end
    end

    assign quotient = sh_reg;
    assign q_valid  = q_valid_reg;

endmodule

// File: rtl/centroid_div_sequencer.sv
// Frame-end centroid sequencer: shares one serial divider for X then Y, gates on blob size.
// Optional CENTROID_ROUND_EN adds sum_1/2 to each dividend for round-to-nearest results.
module centroid_div_sequencer
    import centroid_pkg::*;
#(
    parameter int FRAME_WIDTH   = 640,
    parameter int FRAME_HEIGHT  = 480,
    parameter int MIN_BLOB_SIZE = 300
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [SUM1_W-1:0]  sum_1,
    input  logic [SUMXY_W-1:0] sum_x,
    input  logic [SUMXY_W-1:0] sum_y,
    output logic               busy,
    output logic               done,
    output logic [COORD_W-1:0] centroid_x,
    output logic [COORD_W-1:0] centroid_y,
    output logic               centroid_valid,
    output logic [SUM1_W-1:0]  blob_area,
    output logic               overrun,
    output logic [7:0]         drop_count
);

    localparam logic [SUM1_W-1:0]   MIN_BLOB = SUM1_W'(MIN_BLOB_SIZE);
    localparam logic [DIV_BITS-1:0] X_MAX    = DIV_BITS'(FRAME_WIDTH - 1);
    localparam logic [DIV_BITS-1:0] Y_MAX    = DIV_BITS'(FRAME_HEIGHT - 1);

    state_t state_reg, state_next;

    logic [SUM1_W-1:0]   sum1_reg;
    logic [SUMXY_W-1:0]  sumy_reg;
    logic                blob_ok_reg;
    logic [DIV_BITS-1:0] qx_reg, qy_reg;
    logic                done_reg, valid_reg, overrun_reg;
    logic [COORD_W-1:0]  cx_reg, cy_reg;
    logic [SUM1_W-1:0]   area_reg;
    logic [7:0]          drop_reg;

    logic                div_load;
    logic [SUMXY_W-1:0]  op_sum;
    logic [SUM1_W-1:0]   op_s1;
    logic [DIV_BITS-1:0] div_dividend;
    logic [DIV_BITS-1:0] div_quotient;
    logic                div_q_valid;

    seq_divider u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (div_load),
        .dividend (div_dividend),
        .divisor  (op_s1),
        .quotient (div_quotient),
        .q_valid  (div_q_valid)
    );

    always_comb begin
        state_next = state_reg;
        div_load   = 1'b0;
        op_sum     = sum_x;
        op_s1      = sum_1;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (sum_1 < MIN_BLOB) begin
                        state_next = PUBLISH;
                    end else begin
                        div_load   = 1'b1;
                        state_next = DIV_X;
                    end
                end
            end
            DIV_X: begin
                // Divisor is reloaded from the latched copy; it equals the X divisor.
                op_sum = sumy_reg;
                op_s1  = sum1_reg;
                if (div_q_valid) begin
                    div_load   = 1'b1;
                    state_next = DIV_Y;
                end
            end
            DIV_Y: begin
                op_s1 = sum1_reg;
                if (div_q_valid) begin
                    state_next = PUBLISH;
                end
            end
            PUBLISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
`ifdef CENTROID_ROUND_EN
        div_dividend = {1'b0, op_sum} + {{(DIV_BITS - SUM1_W + 1){1'b0}}, op_s1[SUM1_W-1:1]};
`else
        div_dividend = {1'b0, op_sum};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum1_reg    <= '0;
            sumy_reg    <= '0;
            blob_ok_reg <= 1'b0;
            qx_reg      <= '0;
            qy_reg      <= '0;
            done_reg    <= 1'b0;
            valid_reg   <= 1'b0;
            cx_reg      <= '0;
            cy_reg      <= '0;
            area_reg    <= '0;
            overrun_reg <= 1'b0;
            drop_reg    <= '0;
        end else begin
            done_reg <= (state_reg == PUBLISH);
            if (state_reg == IDLE && start) begin
                sum1_reg    <= sum_1;
                sumy_reg    <= sum_y;
                blob_ok_reg <= (sum_1 >= MIN_BLOB);
            end
            if (state_reg == DIV_X && div_q_valid) begin
                qx_reg <= div_quotient;
            end
            if (state_reg == DIV_Y && div_q_valid) begin
                qy_reg <= div_quotient;
            end
            if (state_reg == PUBLISH) begin
                valid_reg <= blob_ok_reg;
                cx_reg    <= blob_ok_reg ? saturate(qx_reg, X_MAX) : '0;
                cy_reg    <= blob_ok_reg ? saturate(qy_reg, Y_MAX) : '0;
                area_reg  <= sum1_reg;
            end
            // Any start outside IDLE (PUBLISH included) is dropped and counted.
            overrun_reg <= start && (state_reg != IDLE);
            if (start && (state_reg != IDLE) && (drop_reg != 8'hFF)) begin
                drop_reg <= drop_reg + 8'd1;
            end
        end
    end

    assign busy           = (state_reg != IDLE);
    assign done           = done_reg;
    assign centroid_x     = cx_reg;
    assign centroid_y     = cy_reg;
    assign centroid_valid = valid_reg;
    assign blob_area      = area_reg;
    assign overrun        = overrun_reg;
    assign drop_count     = drop_reg;

endmodule

// File: tb/tb_centroid_div_sequencer.sv
// Directed self-checking bench for centroid_div_sequencer (honours CENTROID_ROUND_EN).
module tb_centroid_div_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [19:0] sum_1 = '0;
    logic [28:0] sum_x = '0;
    logic [28:0] sum_y = '0;
    logic        busy, done, centroid_valid, overrun;
    logic [9:0]  centroid_x, centroid_y;
    logic [19:0] blob_area;
    logic [7:0]  drop_count;

    int tests = 0;
    int fails = 0;

`ifdef CENTROID_ROUND_EN
    localparam int EXP_RND_X = 321;
`else
    localparam int EXP_RND_X = 320;
`endif

    centroid_div_sequencer #(
        .FRAME_WIDTH   (640),
        .FRAME_HEIGHT  (480),
        .MIN_BLOB_SIZE (300)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .sum_1          (sum_1),
        .sum_x          (sum_x),
        .sum_y          (sum_y),
        .busy           (busy),
        .done           (done),
        .centroid_x     (centroid_x),
        .centroid_y     (centroid_y),
        .centroid_valid (centroid_valid),
        .blob_area      (blob_area),
        .overrun        (overrun),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drives a one-cycle start; returns just after the sampling edge E0.
    task automatic start_frame(input logic [19:0] s1, input logic [28:0] sx, input logic [28:0] sy);
        @(posedge clk);
        #1;
        sum_1 = s1;
        sum_x = sx;
        sum_y = sy;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after E0 until done is seen, bounded at 200.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 200);
    endtask

    initial begin
        int n;
        int seen;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_x", centroid_x, 0);
        chk("reset_y", centroid_y, 0);
        chk("reset_valid", centroid_valid, 0);
        chk("reset_area", blob_area, 0);
        chk("reset_drop", drop_count, 0);
        rst_n = 1'b1;

        // Basic 320/240 centroid
        start_frame(20'd400, 29'd128000, 29'd96000);
        chk("basic_busy", busy, 1);
        wait_done(n);
        $display("[TB] basic: latency=%0d x=%0d y=%0d v=%0d area=%0d", n, centroid_x, centroid_y, centroid_valid, blob_area);
        chk("basic_latency", n, 61);
        chk("basic_x", centroid_x, 320);
        chk("basic_y", centroid_y, 240);
        chk("basic_valid", centroid_valid, 1);
        chk("basic_area", blob_area, 400);
        chk("basic_idle", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_done_low", done, 0);
        chk("hold_x", centroid_x, 320);

        // Small blob, one below the minimum
        start_frame(20'd299, 29'd5000, 29'd7000);
        wait_done(n);
        $display("[TB] small: latency=%0d x=%0d y=%0d v=%0d area=%0d", n, centroid_x, centroid_y, centroid_valid, blob_area);
        chk("small_latency", n, 1);
        chk("small_valid", centroid_valid, 0);
        chk("small_x", centroid_x, 0);
        chk("small_y", centroid_y, 0);
        chk("small_area", blob_area, 299);

        // Rounding of 320.75
        start_frame(20'd400, 29'd128300, 29'd96000);
        wait_done(n);
        $display("[TB] round: latency=%0d x=%0d y=%0d", n, centroid_x, centroid_y);
        chk("round_latency", n, 61);
        chk("round_x", centroid_x, EXP_RND_X);
        chk("round_y", centroid_y, 240);

        // Saturation to frame bounds
        start_frame(20'd400, 29'd280000, 29'd200000);
        wait_done(n);
        $display("[TB] sat: x=%0d y=%0d v=%0d", centroid_x, centroid_y, centroid_valid);
        chk("sat_x", centroid_x, 639);
        chk("sat_y", centroid_y, 479);
        chk("sat_valid", centroid_valid, 1);

        // Exactly the minimum blob size is valid: 3000/300, 6000/300
        start_frame(20'd300, 29'd3000, 29'd6000);
        wait_done(n);
        $display("[TB] min: latency=%0d x=%0d y=%0d v=%0d", n, centroid_x, centroid_y, centroid_valid);
        chk("min_latency", n, 61);
        chk("min_x", centroid_x, 10);
        chk("min_y", centroid_y, 20);
        chk("min_valid", centroid_valid, 1);

        // Empty frame
        start_frame(20'd0, 29'd0, 29'd0);
        wait_done(n);
        $display("[TB] empty: latency=%0d v=%0d area=%0d", n, centroid_valid, blob_area);
        chk("empty_latency", n, 1);
        chk("empty_valid", centroid_valid, 0);
        chk("empty_x", centroid_x, 0);

        // Overrun: second start 10 cycles in with different sums
        start_frame(20'd400, 29'd128000, 29'd96000);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 10) begin
                sum_1 = 20'd500;
                sum_x = 29'd50000;
                sum_y = 29'd50000;
                start = 1'b1;
            end else if (n == 11) begin
                start = 1'b0;
                chk("ovr_pulse", overrun, 1);
                chk("ovr_drop", drop_count, 1);
            end else if (n == 12) begin
                chk("ovr_pulse_end", overrun, 0);
            end
        end while (!done && n < 200);
        $display("[TB] overrun: latency=%0d x=%0d y=%0d area=%0d drops=%0d", n, centroid_x, centroid_y, blob_area, drop_count);
        chk("ovr_latency", n, 61);
        chk("ovr_x", centroid_x, 320);
        chk("ovr_y", centroid_y, 240);
        chk("ovr_area", blob_area, 400);

        // Reset asserted during DIV_Y
        start_frame(20'd400, 29'd40000, 29'd80000);
        repeat (40) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        $display("[TB] midreset: busy=%0d x=%0d y=%0d drops=%0d", busy, centroid_x, centroid_y, drop_count);
        chk("mrst_busy", busy, 0);
        chk("mrst_x", centroid_x, 0);
        chk("mrst_y", centroid_y, 0);
        chk("mrst_area", blob_area, 0);
        chk("mrst_drop", drop_count, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        chk("mrst_no_done", seen, 0);
        chk("mrst_idle", busy, 0);

        // Fresh frame after reset: 40000/400, 80000/400
        start_frame(20'd400, 29'd40000, 29'd80000);
        wait_done(n);
        $display("[TB] post-reset: latency=%0d x=%0d y=%0d v=%0d", n, centroid_x, centroid_y, centroid_valid);
        chk("post_latency", n, 61);
        chk("post_x", centroid_x, 100);
        chk("post_y", centroid_y, 200);
        chk("post_valid", centroid_valid, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
